// File: rtl/sixteen_adder_pkg.sv
// rtl/sixteen_adder_pkg.sv - shared width constants for the 16-bit lookahead adder
//
// Purpose : single place for the datapath width and lookahead group size.
// Ports   : none (package).
package sixteen_adder_pkg;

    localparam int WIDTH   = 16;
    localparam int GROUP   = 4;
    localparam int NGROUPS = WIDTH / GROUP;

endpackage

// File: rtl/sixteen_adder_cla4_group.sv
// rtl/sixteen_adder_cla4_group.sv - 4-bit carry-lookahead group for the 16-bit adder
//
// Purpose : first-level lookahead. Produces the four sum bits from the group
//           carry-in, plus group generate/propagate for the second level.
// Ports   : a[3:0], b[3:0] - operand slices
//           ci             - carry into the least significant bit of the group
//           s[3:0]         - sum bits of the group
//           G              - group generate (group makes a carry on its own)
//           P              - group propagate (group passes ci straight through)
module sixteen_adder_cla4_group
    import sixteen_adder_pkg::*;
(
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             G,
    output logic             P
);

    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Internal carries are flattened sums of products so no carry depends on
    // the carry of a lower bit in the group.
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & ci);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);

    assign s = w_p ^ w_c;

    // Group terms exclude ci; the second-level unit folds the carry-in in.
    assign G = w_g[3]
             | (w_p[3] & w_g[2])
             | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign P = &w_p;

endmodule

// File: rtl/sixteen_adder.sv
// rtl/sixteen_adder.sv - registered 16-bit two-level carry-lookahead adder
//
// Purpose : {Cout, S} <= A + B + Cin on every rising clk edge (one-cycle latency,
//           one add per cycle). Four 4-bit lookahead groups plus a second-level
//           lookahead unit for the group carries.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset; clears S and Cout at once
//           A, B  - 16-bit unsigned operands
//           Cin   - carry into bit 0
//           S     - registered sum bits [15:0]
//           Cout  - registered carry out of bit 15
module sixteen_adder
    import sixteen_adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    logic [NGROUPS-1:0] w_grp_g;
    logic [NGROUPS-1:0] w_grp_p;
    logic [NGROUPS-1:0] w_grp_ci;   // carry into each group: Cin, c4, c8, c12
    logic               w_c16;
    logic [WIDTH-1:0]   w_sum;

    logic [WIDTH-1:0]   r_s;
    logic               r_cout;

    for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
        sixteen_adder_cla4_group u_grp (
            .a  (A[k*GROUP +: GROUP]),
            .b  (B[k*GROUP +: GROUP]),
            .ci (w_grp_ci[k]),
            .s  (w_sum[k*GROUP +: GROUP]),
            .G  (w_grp_g[k]),
            .P  (w_grp_p[k])
        );
    end

    // Second-level lookahead: every group carry is a direct function of Cin
    // and the group G/P terms, so the path Cin -> c16 is two AND-OR levels deep
    // instead of a 16-bit ripple.
    assign w_grp_ci[0] = Cin;
    assign w_grp_ci[1] = w_grp_g[0]
                       | (w_grp_p[0] & Cin);
    assign w_grp_ci[2] = w_grp_g[1]
                       | (w_grp_p[1] & w_grp_g[0])
                       | (w_grp_p[1] & w_grp_p[0] & Cin);
    assign w_grp_ci[3] = w_grp_g[2]
                       | (w_grp_p[2] & w_grp_g[1])
                       | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                       | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & Cin);
    assign w_c16       = w_grp_g[3]
                       | (w_grp_p[3] & w_grp_g[2])
                       | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
                       | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                       | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & Cin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_c16;
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;

endmodule

// File: tb/tb_sixteen_adder.sv
// tb/tb_sixteen_adder.sv - self-checking scoreboard bench for sixteen_adder
module tb_sixteen_adder;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [15:0] S;
    logic        Cout;

    int n_checks;
    int n_errors;

    logic [16:0] sb_q[$];

    sixteen_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .S     (S),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {Cout,S}=%h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] r;
        r = {1'b0, a} + {1'b0, b} + {16'd0, c};
        return r;
    endfunction

    // Called #1 after a rising edge: drive operands, push expectation,
    // then compare after the edge that samples them.
    task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] exp;
        A   = a;
        B   = b;
        Cin = c;
        sb_q.push_back(model(a, b, c));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, {Cout, S}, 17'h1_FFFF ^ {Cout, S});
        end else begin
            exp = sb_q.pop_front();
            check(tag, {Cout, S}, exp);
        end
    endtask

    initial begin
        #200000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        rst_n = 1'b0;
        A     = 16'hA5A5;
        B     = 16'h5A5B;
        Cin   = 1'b1;
        #1;
        check("reset_t0", {Cout, S}, 17'h0_0000);
        @(posedge clk);
        #1;
        check("reset_edge1", {Cout, S}, 17'h0_0000);
        @(posedge clk);
        #1;
        check("reset_edge2", {Cout, S}, 17'h0_0000);

        rst_n = 1'b1;
        step("after_release", 16'hA5A5, 16'h5A5B, 1'b1);
        step("mixed",        16'h96D9, 16'hF7DE, 1'b0);
        step("full_prop",    16'hFFFF, 16'h0000, 1'b1);
        step("grp_boundary", 16'h7FFF, 16'h0001, 1'b0);
        step("zero",         16'h0000, 16'h0000, 1'b0);
        step("max_sum",      16'hFFFF, 16'hFFFF, 1'b1);
        step("cin_only",     16'h0000, 16'h0000, 1'b1);
        step("grp_chain",    16'h0FFF, 16'h0000, 1'b1);
        step("grp_gen",      16'h00F0, 16'h0010, 1'b0);
        step("no_cout_edge", 16'hFFFE, 16'h0000, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            step("random", 16'($urandom), 16'($urandom), 1'($urandom));
        end

        // Mid-operation reset: outputs must clear between edges.
        step("pre_midreset", 16'hFFFF, 16'hFFFF, 1'b0);
        A   = 16'h1234;
        B   = 16'hF00F;
        Cin = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async", {Cout, S}, 17'h0_0000);
        @(posedge clk);
        #1;
        check("midreset_hold", {Cout, S}, 17'h0_0000);
        rst_n = 1'b1;
        sb_q.delete();
        step("post_midreset", 16'h1234, 16'hF00F, 1'b1);
        step("final",         16'h8000, 16'h8000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
